// File: rtl/led_drv_pkg.sv
// led_drv_pkg: PIO word field map, PWM widths and duty-to-compare mapping
// shared by led_pwm_driver and led_pwm_channel.
// Optional build macro: LED_GAMMA_EN -- duty is mapped through GAMMA_LUT
// instead of the linear {d,d} expansion; the LUT only exists when defined.
package led_drv_pkg;

    // Channel count and field widths
    localparam int NUM_CH = 3;
    localparam int DUTY_W = 4;
    localparam int PWM_W  = 8;
    localparam int RATE_W = 4;

    // Bit positions inside the 32-bit PIO word
    localparam int EN_LSB        = 0;
    localparam int BLINK_LSB     = 4;
    localparam int DUTY_LSB      = 8;
    localparam int RATE_LSB      = 24;
    localparam int PHASE_CLR_BIT = 31;

    typedef logic [DUTY_W-1:0] duty_t;
    typedef logic [PWM_W-1:0]  pwm_t;

    // Full-scale duty: channel is held on for the whole frame
    localparam duty_t DUTY_MAX = '1;

`ifdef LED_GAMMA_EN
    // Perceptual brightness curve, indexed by duty
    localparam pwm_t GAMMA_LUT [0:15] = '{
        8'd0,   8'd1,   8'd2,   8'd4,   8'd7,   8'd11,  8'd16,  8'd23,
        8'd32,  8'd43,  8'd56,  8'd72,  8'd91,  8'd114, 8'd141, 8'd255
    };
`endif

    // Duty code to PWM compare threshold: LED is lit while pwm_cnt < threshold
    function automatic pwm_t duty_to_cmp(input duty_t duty);
`ifdef LED_GAMMA_EN
        return GAMMA_LUT[duty];
`else
        return {duty, duty};
`endif
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED channel. Compares the shared PWM counter against
// the channel's duty threshold, applies enable and blink gating, and drives
// a registered active-low output (1 = dark).
// Optional build macro: LED_GAMMA_EN (selects the duty map in led_drv_pkg).
module led_pwm_channel
    import led_drv_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  logic  blink,
    input  duty_t duty,
    input  pwm_t  pwm_cnt,
    input  logic  phase,
    output logic  led_n
);

    pwm_t cmp;
    logic on;

    // Lit decision; full-scale duty bypasses the compare so there is no
    // one-tick dark gap at pwm_cnt == 255
    always_comb begin
        cmp = duty_to_cmp(duty);
        on  = en && ((duty == DUTY_MAX) || (pwm_cnt < cmp)) && !(blink && phase);
    end

    // Register the pin drive, dark in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_n <= 1'b1;
        end else begin
            led_n <= !on;
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: drives three active-low board LEDs from the PIO output
// word with per-channel enable, 4-bit PWM brightness and blink. The word is
// sampled every cycle but only applied (shadowed) at PWM frame boundaries,
// so brightness/blink changes are glitch-free.
// Optional build macro: LED_GAMMA_EN -- gamma-corrected duty mapping.
module led_pwm_driver
    import led_drv_pkg::*;
#(
    parameter int PRESCALE = 49,
    parameter int BLINK_W  = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] PIO_WORD,
    output logic [2:0]  LED,
    output logic        FRAME_STROBE,
    output logic        CFG_PENDING
);

    localparam int PRESC_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE);

    logic [31:0]        pio_q;
    logic [31:0]        shadow;
    logic [PRESC_W-1:0] presc;
    pwm_t               pwm_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               tick;
    logic               frame_end;
    logic               phase;
    logic [RATE_W-1:0]  rate;

    // Tick and frame boundary decode; the frame ends on the tick that wraps pwm_cnt
    always_comb begin
        tick      = (presc == PRESC_LAST);
        frame_end = tick && (pwm_cnt == '1);
    end

    // Blink phase: blink_cnt[rate]; a rate beyond the counter width shifts
    // the select mask out entirely, so the phase reads as 0
    always_comb begin
        rate  = shadow[RATE_LSB +: RATE_W];
        phase = |(blink_cnt & (BLINK_W'(1) << rate));
    end

    // Sample the PIO word every cycle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pio_q <= '0;
        end else begin
            pio_q <= PIO_WORD;
        end
    end

    // Prescaler: counts 0..PRESCALE, one PWM tick per wrap
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // PWM counter, free-running modulo 256 in ticks
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    // Apply the sampled word and advance/clear the blink counter at frame end
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            shadow    <= '0;
            blink_cnt <= '0;
        end else if (frame_end) begin
            shadow    <= pio_q;
            blink_cnt <= pio_q[PHASE_CLR_BIT] ? '0 : blink_cnt + BLINK_W'(1);
        end
    end

    // Frame strobe lands on the first cycle of the new shadow; pending
    // is suppressed on the apply cycle since the shadow catches up there
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            FRAME_STROBE <= 1'b0;
            CFG_PENDING  <= 1'b0;
        end else begin
            FRAME_STROBE <= frame_end;
            CFG_PENDING  <= (pio_q != shadow) && !frame_end;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_pwm_channel u_ch (
            .clk     (CLK),
            .rst_n   (RESET_N),
            .en      (shadow[EN_LSB + i]),
            .blink   (shadow[BLINK_LSB + i]),
            .duty    (shadow[DUTY_LSB + i*DUTY_W +: DUTY_W]),
            .pwm_cnt (pwm_cnt),
            .phase   (phase),
            .led_n   (LED[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: scoreboard bench for led_pwm_driver at PRESCALE=0.
// Cycle t counts rising edges since reset release (release happens at a
// falling edge, so that half-cycle is cycle 0). The word present during
// cycle 256f-2 is the one applied to frame f; frame f's LED pattern shows
// on cycles 256f+1 .. 256f+256.
module tb_led_pwm_driver;

    localparam int unsigned HIST_N = 16384;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic [31:0] PIO_WORD = 32'hFFFF_FFFF;
    logic [2:0]  LED;
    logic        FRAME_STROBE;
    logic        CFG_PENDING;

    led_pwm_driver #(
        .PRESCALE (0),
        .BLINK_W  (16)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .PIO_WORD     (PIO_WORD),
        .LED          (LED),
        .FRAME_STROBE (FRAME_STROBE),
        .CFG_PENDING  (CFG_PENDING)
    );

    always #5 CLK = ~CLK;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    int unsigned next_c = 0;
    int unsigned frames_done = 0;

    typedef struct packed {
        logic [31:0] frame;
        logic [8:0]  n2;
        logic [8:0]  n1;
        logic [8:0]  n0;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hist [HIST_N];
    logic [15:0] blink_m = '0;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp, input int unsigned at);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, at, got, exp);
        end
    endtask

    // Number of lit ticks per 256-tick frame for one channel
    function automatic logic [8:0] exp_lit(input logic [31:0] w, input int unsigned ch, input logic [15:0] bc);
        logic        en, bl, ph;
        int unsigned d, r;
        en = ((w >> ch) & 32'd1) != 0;
        bl = ((w >> (4 + ch)) & 32'd1) != 0;
        d  = (w >> (8 + 4*ch)) & 32'hF;
        r  = (w >> 24) & 32'hF;
        ph = (r < 16) ? (((bc >> r) & 16'd1) != 0) : 1'b0;
        if (!en || (bl && ph)) return 9'd0;
        if (d == 15) return 9'd256;
`ifdef LED_GAMMA_EN
        case (d)
            0: return 9'd0;     1: return 9'd1;     2: return 9'd2;     3: return 9'd4;
            4: return 9'd7;     5: return 9'd11;    6: return 9'd16;    7: return 9'd23;
            8: return 9'd32;    9: return 9'd43;    10: return 9'd56;   11: return 9'd72;
            12: return 9'd91;   13: return 9'd114;  default: return 9'd141;
        endcase
`else
        return 9'(17 * d);
`endif
    endfunction

    task automatic push_frame(input logic [31:0] w, input int unsigned f);
        exp_t e;
        blink_m = w[31] ? 16'd0 : blink_m + 16'd1;
        e.frame = f;
        e.n0 = exp_lit(w, 0, blink_m);
        e.n1 = exp_lit(w, 1, blink_m);
        e.n2 = exp_lit(w, 2, blink_m);
        sb.push_back(e);
    endtask

    task automatic step(input logic [31:0] w);
        @(negedge CLK);
        PIO_WORD = w;
        if (cyc < HIST_N) hist[cyc] = w;
        if (cyc % 256 == 254) push_frame(w, cyc / 256 + 1);
        next_c = cyc + 1;
    endtask

    task automatic drive_to(input logic [31:0] w, input int unsigned end_c);
        while (next_c < end_c) step(w);
    endtask

    task automatic start_run();
        @(negedge CLK);
        PIO_WORD = 32'h0;
        hist[0]  = 32'h0;
        RESET_N  = 1'b1;
        next_c   = 1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_led"},     32'(LED),          32'h7, cyc);
        chk({tag, "_strobe"},  32'(FRAME_STROBE), 32'h0, cyc);
        chk({tag, "_pending"}, 32'(CFG_PENDING),  32'h0, cyc);
    endtask

    function automatic logic [31:0] applied(input int unsigned f);
        if (f == 0) return 32'h0;
        return hist[256*f - 2];
    endfunction

    logic        collecting = 1'b0;
    int unsigned idx = 0;
    int unsigned lows [3];
    logic        seen_hi [3];
    logic        broken [3];

    always @(negedge CLK) begin : monitor
        int unsigned t, u;
        logic [31:0] qv;
        logic        exp_p;
        exp_t        e;
        logic [8:0]  n;
        if (!RESET_N) begin
            collecting = 1'b0;
        end else begin
            t = cyc;
            chk("frame_strobe", 32'(FRAME_STROBE), 32'((t != 0) && (t % 256 == 0)), t);
            exp_p = 1'b0;
            if (t >= 1 && t < HIST_N) begin
                u     = t - 1;
                qv    = (u == 0) ? 32'h0 : hist[u-1];
                exp_p = (qv != applied(u / 256)) && (u % 256 != 255);
            end
            chk("cfg_pending", 32'(CFG_PENDING), 32'(exp_p), t);
            if (t <= 256) chk("led_frame0", 32'(LED), 32'h7, t);
            if (collecting) begin
                for (int ch = 0; ch < 3; ch++) begin
                    if (LED[ch] == 1'b0) begin
                        lows[ch]++;
                        if (seen_hi[ch]) broken[ch] = 1'b1;
                    end else begin
                        seen_hi[ch] = 1'b1;
                    end
                end
                idx++;
                if (idx == 256) begin
                    collecting = 1'b0;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard_empty cyc=%0d got=frame_end exp=no_frame", t);
                    end else begin
                        e = sb.pop_front();
                        frames_done++;
                        for (int ch = 0; ch < 3; ch++) begin
                            n = (ch == 0) ? e.n0 : (ch == 1) ? e.n1 : e.n2;
                            checks++;
                            if (lows[ch] != 32'(n) || broken[ch]) begin
                                failures++;
                                $display("FAIL led%0d_frame%0d lit=%0d contiguous=%0b exp_lit=%0d exp_contiguous=1",
                                         ch, e.frame, lows[ch], !broken[ch], n);
                            end
                        end
                    end
                end
            end
            if (FRAME_STROBE) begin
                collecting = 1'b1;
                idx = 0;
                for (int ch = 0; ch < 3; ch++) begin
                    lows[ch] = 0;
                    seen_hi[ch] = 1'b0;
                    broken[ch] = 1'b0;
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] w;
        int unsigned endc;
        // Reset with an all-ones word on the bus
        #3 RESET_N = 1'b0;
        #1 reset_checks("reset_async");
        repeat (4) @(negedge CLK);
        reset_checks("reset_hold");
        start_run();

        // Hold zero, then single full-on channel written at pwm_cnt=10
        drive_to(32'h0000_0000, 266);
        drive_to(32'h0000_0F01, 256*5);
        // Mid duty on channel 1
        drive_to(32'h0000_8002, 256*8);
        // Channel 2 blinking at rate 0, full duty
        drive_to(32'h000F_0044, 256*12 + 100);
        // Two writes mid-frame, last one wins
        drive_to(32'h0000_0F01, 256*12 + 101);
        // Change on the frame_end cycle itself lands a frame later
        drive_to(32'h0000_F002, 256*14 - 1);
        drive_to(32'h0000_0F01, 256*16);
        // Phase clear, then blink restarts from 0
        drive_to(32'h8000_0F01, 256*17);
        drive_to(32'h000F_0044, 256*20);

        // Random words held for random spans
        while (next_c < 256*32) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[27:24] = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) w[31] = 1'b0;
            endc = next_c + $urandom_range(1, 400);
            if (endc > 256*32) endc = 256*32;
            drive_to(w, endc);
        end

        // Reset pulse mid-frame while blinking
        drive_to(32'h000F_0F45, 256*33 + 77);
        @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1 reset_checks("reset_mid");
        sb.delete();
        blink_m = '0;
        repeat (3) @(negedge CLK);
        start_run();
        drive_to(32'h000F_0F45, 256*4 + 4);

        chk("frames_checked", frames_done, 32'd35, cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
